// File: rtl/zpu_sd_bridge.sv
// rtl/zpu_sd_bridge.sv - ZPU register port to hps_io SD block bridge with sector buffer
// Holds the dual-port sector buffer, LBA latch, block request handshake and image mount state.
module zpu_sd_bridge #(
    parameter int BUF_AW = 9
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       zpu_out2,
    input  logic [31:0]       zpu_out3,
    input  logic              zpu_io_wr,
    input  logic              zpu_data_wr,
    input  logic              zpu_data_rd,
    output logic [7:0]        zpu_in2,
    output logic [31:0]       zpu_in3,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    input  logic              img_mounted,
    input  logic [63:0]       img_size,
    input  logic [7:0]        ioctl_index
);
    localparam int DEPTH = 1 << BUF_AW;
    localparam logic [BUF_AW-1:0] PTR_ONE = 1;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        a_dout_q, b_dout_q;
    logic [BUF_AW-1:0] ptr_q, ptr_d;
    logic              w1_q, w2_q, r1_q, wr_inc_q, wr_inc_d;
    logic              ack_q, blk_rd_q, blk_wr_q, mnt_q, first_q;
    logic [31:0]       lba_q, lba_d, fsize_q, fsize_d;
    logic              sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d, done_q, done_d;
    logic              mounted_q, mounted_d, ro_q, ro_d;
    logic [1:0]        ftype_q, ftype_d;
    logic [2:0]        fileno_q, fileno_d;

    logic lba_sel, wr_edge, rd_fall, ram_we, blk_rd_rise, blk_wr_rise, ack_fall, mnt_rise;
    logic unused_bits;

    assign lba_sel     = zpu_out2[0];
    assign wr_edge     = w1_q & ~w2_q;
    assign rd_fall     = r1_q & ~zpu_data_rd;
    assign ram_we      = wr_edge & ~lba_sel;
    assign blk_rd_rise = zpu_out2[1] & ~blk_rd_q;
    assign blk_wr_rise = zpu_out2[2] & ~blk_wr_q;
    assign ack_fall    = ack_q & ~sd_ack;
    assign mnt_rise    = img_mounted & ~mnt_q;
    assign unused_bits = ^{zpu_out2[31:3], img_size[63:32], ioctl_index[5:0]};

    // Both ports share one array; a same-address collision resolves in favour of the ZPU write.
    always_ff @(posedge clk_sys) begin
        if (sd_buff_wr) mem[sd_buff_addr] <= sd_buff_dout;
        if (ram_we) mem[ptr_q] <= zpu_out3[7:0];
        a_dout_q <= mem[sd_buff_addr];
        b_dout_q <= mem[ptr_q];
    end

    always_comb begin
        ptr_d     = ptr_q;
        wr_inc_d  = ram_we;
        lba_d     = lba_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        done_d    = done_q;
        mounted_d = mounted_q;
        ro_d      = ro_q;
        ftype_d   = ftype_q;
        fileno_d  = fileno_q;
        fsize_d   = fsize_q;

        if (zpu_io_wr) ptr_d = '0;
        else if (wr_inc_q || rd_fall) ptr_d = ptr_q + PTR_ONE;

        if (wr_edge && lba_sel) lba_d = zpu_out3;

        // An active acknowledge always wins over a new request edge.
        if (sd_ack) begin
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b0;
        end else if (ack_fall) begin
            done_d = 1'b1;
        end else if (done_q) begin
            if (blk_rd_rise) begin
                sd_rd_d = 1'b1;
                done_d  = 1'b0;
            end else if (blk_wr_rise) begin
                sd_wr_d = 1'b1;
                done_d  = 1'b0;
            end
        end

        if (mnt_rise) begin
            fileno_d  = 3'd0;
            ftype_d   = ioctl_index[7:6];
            ro_d      = 1'b1;
            mounted_d = ~mounted_q;
            fsize_d   = img_size[31:0];
        end else if (first_q) begin
            mounted_d = |img_size[31:0];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            w1_q      <= 1'b0;
            w2_q      <= 1'b0;
            r1_q      <= 1'b0;
            wr_inc_q  <= 1'b0;
            ack_q     <= 1'b0;
            blk_rd_q  <= 1'b0;
            blk_wr_q  <= 1'b0;
            mnt_q     <= 1'b0;
            first_q   <= 1'b1;
            lba_q     <= '0;
            fsize_q   <= '0;
            sd_rd_q   <= 1'b0;
            sd_wr_q   <= 1'b0;
            done_q    <= 1'b1;
            mounted_q <= 1'b0;
            ro_q      <= 1'b0;
            ftype_q   <= '0;
            fileno_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            w1_q      <= zpu_data_wr;
            w2_q      <= w1_q;
            r1_q      <= zpu_data_rd;
            wr_inc_q  <= wr_inc_d;
            ack_q     <= sd_ack;
            blk_rd_q  <= zpu_out2[1];
            blk_wr_q  <= zpu_out2[2];
            mnt_q     <= img_mounted;
            first_q   <= 1'b0;
            lba_q     <= lba_d;
            fsize_q   <= fsize_d;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            done_q    <= done_d;
            mounted_q <= mounted_d;
            ro_q      <= ro_d;
            ftype_q   <= ftype_d;
            fileno_q  <= fileno_d;
        end
    end

    assign zpu_in2     = {ro_q, ftype_q, fileno_q, mounted_q, done_q};
    assign zpu_in3     = lba_sel ? fsize_q : {24'b0, b_dout_q};
    assign sd_lba      = lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = a_dout_q;
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// tb/tb_zpu_sd_bridge.sv - randomized self-checking bench for zpu_sd_bridge
// Transaction-level model of buffer, pointer, request and mount state; compared every settled cycle.
module tb_zpu_sd_bridge;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] zpu_out2, zpu_out3;
    logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
    logic [7:0]  zpu_in2;
    logic [31:0] zpu_in3, sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr, img_mounted;
    logic [63:0] img_size;
    logic [7:0]  ioctl_index;

    always #5 clk = ~clk;

    zpu_sd_bridge #(.BUF_AW(9)) dut (
        .clk_sys(clk), .reset(reset),
        .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
        .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
        .zpu_in2(zpu_in2), .zpu_in3(zpu_in3),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .img_mounted(img_mounted), .img_size(img_size), .ioctl_index(ioctl_index)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_lba, m_fsize;
    bit          m_rd, m_wr, m_done, m_mounted, m_ro;
    logic [1:0]  m_ftype;
    int          m_ptr;
    logic [7:0]  m_mem [DEPTH];
    bit          m_valid [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("sd_lba", sd_lba, m_lba);
            chk("sd_rd", sd_rd, m_rd);
            chk("sd_wr", sd_wr, m_wr);
            chk("zpu_in2", zpu_in2, {m_ro, m_ftype, 3'b000, m_mounted, m_done});
            if (zpu_out2[0]) chk("in3_filesize", zpu_in3, m_fsize);
            else if (m_valid[m_ptr]) chk("in3_byte", zpu_in3, {24'b0, m_mem[m_ptr]});
        end
    end

    function automatic logic [31:0] junk(input logic [2:0] low);
        logic [31:0] r;
        r = $urandom();
        return {r[31:3], low};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic model_reset();
        m_lba = '0; m_rd = 0; m_wr = 0; m_done = 1; m_mounted = 0;
        m_ro = 0; m_ftype = '0; m_fsize = '0; m_ptr = 0;
    endtask

    task automatic zpu_write(input logic sel, input logic [31:0] val);
        step();
        chk_en = 0;
        zpu_out2 = junk({2'b00, sel});
        zpu_out3 = val;
        zpu_data_wr = 1;
        steps($urandom_range(1, 4));
        zpu_data_wr = 0;
        steps(4);
        if (sel) m_lba = val;
        else begin
            m_mem[m_ptr] = val[7:0];
            m_valid[m_ptr] = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
        end
        zpu_out2 = junk(3'b000);
        chk_en = 1;
    endtask

    task automatic zpu_read();
        step();
        chk_en = 0;
        zpu_data_rd = 1;
        steps($urandom_range(1, 4));
        zpu_data_rd = 0;
        steps(3);
        m_ptr = (m_ptr + 1) % DEPTH;
        chk_en = 1;
    endtask

    task automatic io_clear();
        step();
        chk_en = 0;
        zpu_io_wr = 1;
        steps($urandom_range(1, 3));
        zpu_io_wr = 0;
        steps(2);
        m_ptr = 0;
        chk_en = 1;
    endtask

    task automatic hps_write(input int a, input logic [7:0] d);
        step();
        chk_en = 0;
        sd_buff_addr = 9'(a);
        sd_buff_dout = d;
        sd_buff_wr = 1;
        step();
        sd_buff_wr = 0;
        m_mem[a] = d;
        m_valid[a] = 1;
        step();
        chk_en = 1;
    endtask

    task automatic hps_read(input int a);
        step();
        sd_buff_addr = 9'(a);
        step();
        @(negedge clk);
        if (m_valid[a]) chk("hps_read", sd_buff_din, m_mem[a]);
    endtask

    // Write whose pointer increment lands on the same cycle as a read-strobe falling edge.
    task automatic coincide(input logic [7:0] b);
        step();
        chk_en = 0;
        zpu_out2 = junk(3'b000);
        zpu_out3 = {24'b0, b};
        zpu_data_wr = 1;
        step();
        zpu_data_rd = 1;
        step();
        zpu_data_rd = 0;
        step();
        zpu_data_wr = 0;
        steps(4);
        m_mem[m_ptr] = b; m_valid[m_ptr] = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        chk_en = 1;
    endtask

    task automatic override(input logic [7:0] b);
        step();
        chk_en = 0;
        zpu_out2 = junk(3'b000);
        zpu_out3 = {24'b0, b};
        zpu_data_wr = 1;
        step();
        step();
        zpu_io_wr = 1;
        step();
        zpu_io_wr = 0;
        zpu_data_wr = 0;
        steps(4);
        m_mem[m_ptr] = b; m_valid[m_ptr] = 1;
        m_ptr = 0;
        chk_en = 1;
    endtask

    task automatic do_block(input int kind);
        logic [2:0] bits;
        bits = (kind == 0) ? 3'b010 : (kind == 1) ? 3'b100 : 3'b110;
        step();
        chk_en = 0;
        zpu_out2 = junk(bits);
        step();
        m_rd = (kind != 1); m_wr = (kind == 1); m_done = 0;
        @(negedge clk);
        chk("blk_sd_rd", sd_rd, kind != 1);
        chk("blk_sd_wr", sd_wr, kind == 1);
        chk("blk_busy", zpu_in2[0], 1'b0);
        chk_en = 1;
        steps($urandom_range(1, 3));
        sd_ack = 1;
        chk_en = 0;
        step();
        m_rd = 0; m_wr = 0;
        chk_en = 1;
        zpu_out2 = junk(3'b000);
        step();
        zpu_out2 = junk(bits);
        steps($urandom_range(0, 2));
        sd_ack = 0;
        chk_en = 0;
        step();
        m_done = 1;
        chk_en = 1;
        zpu_out2 = junk(3'b000);
        steps(2);
    endtask

    task automatic do_mount(input logic [7:0] idx, input logic [63:0] sz);
        step();
        chk_en = 0;
        ioctl_index = idx;
        img_size = sz;
        img_mounted = 1;
        steps($urandom_range(1, 3));
        img_mounted = 0;
        step();
        m_ftype = idx[7:6]; m_ro = 1; m_mounted = ~m_mounted; m_fsize = sz[31:0];
        chk_en = 1;
    endtask

    task automatic wiggle();
        logic sel;
        step();
        sel = 1'($urandom_range(0, 1));
        img_size = {$urandom(), $urandom()};
        ioctl_index = 8'($urandom());
        zpu_out3 = $urandom();
        zpu_out2 = junk({2'b00, sel});
        steps($urandom_range(1, 3));
    endtask

    initial begin
        reset = 1; zpu_out2 = 32'h1; zpu_out3 = '0;
        zpu_io_wr = 0; zpu_data_wr = 0; zpu_data_rd = 0; sd_ack = 0;
        sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
        img_mounted = 0; img_size = '0; ioctl_index = '0;
        model_reset();
        steps(3);
        @(negedge clk);
        chk("rst_in2", zpu_in2, 8'h01);
        chk("rst_lba", sd_lba, 32'h0);
        chk("rst_req", {sd_rd, sd_wr}, 2'b00);
        chk("rst_filesize", zpu_in3, 32'h0);

        step();
        img_size = 64'h2000;
        reset = 0;
        step();
        @(negedge clk);
        chk("post_rst_in2", zpu_in2, 8'h03);
        m_mounted = 1;
        chk_en = 1;

        io_clear();
        for (int i = 0; i < DEPTH; i++) zpu_write(1'b0, 32'(i & 255));
        @(negedge clk);
        chk("wrap_byte0", zpu_in3, 32'h0);
        hps_read(9'h1FF);
        chk("hps_1ff", sd_buff_din, 8'hFF);

        zpu_write(1'b1, 32'h0000_0123);
        @(negedge clk);
        chk("lba_123", sd_lba, 32'h123);
        chk("lba_no_ptr_move", zpu_in3, 32'h0);
        hps_read(0);
        chk("lba_no_ram_write", sd_buff_din, 8'h00);

        zpu_read();
        zpu_read();
        @(negedge clk);
        chk("rd_byte2", zpu_in3, 32'h2);
        coincide(8'hEE);
        @(negedge clk);
        chk("single_inc", zpu_in3, 32'h3);
        override(8'hC3);
        @(negedge clk);
        chk("io_wr_override", zpu_in3, 32'h0);

        do_block(0);
        do_block(2);
        do_block(1);

        do_mount(8'h40, 64'h8000);
        @(negedge clk);
        chk("mount_in2", zpu_in2, 8'hA1);
        step();
        zpu_out2 = junk(3'b001);
        @(negedge clk);
        chk("mount_filesize", zpu_in3, 32'h8000);

        step();
        chk_en = 0;
        zpu_out2 = 32'h4;
        step();
        chk("pre_rst_wr", sd_wr, 1'b1);
        reset = 1;
        #1;
        chk("rst_drops_wr", sd_wr, 1'b0);
        chk("rst_done", zpu_in2[0], 1'b1);
        zpu_out2 = '0;
        img_size = '0;
        sd_buff_addr = 9'd5; sd_buff_dout = 8'h5A; sd_buff_wr = 1;
        step();
        sd_buff_wr = 0;
        m_mem[5] = 8'h5A; m_valid[5] = 1;
        step();
        reset = 0;
        model_reset();
        step();
        @(negedge clk);
        chk("rst2_in2", zpu_in2, 8'h01);
        chk_en = 1;
        hps_read(5);
        chk("hps_wr_in_reset", sd_buff_din, 8'h5A);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 8))
                0, 1: zpu_write(1'b0, $urandom());
                2:    zpu_write(1'b1, $urandom());
                3:    zpu_read();
                4:    hps_write($urandom_range(0, DEPTH - 1), 8'($urandom()));
                5:    hps_read($urandom_range(0, DEPTH - 1));
                6:    if ($urandom_range(0, 3) == 0) io_clear(); else wiggle();
                7:    do_block($urandom_range(0, 2));
                default: do_mount(8'($urandom()), {$urandom(), $urandom()});
            endcase
        end
        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
